nipcb_recording_reader: RTL and testbench

//  Drains the recording FIFO that nipcb_core fills and unpacks each 32-bit word (4 channels x 8 bits,
//  ch0 in [7:0]) into per-channel samples on a valid/ready stream.

---
 rtl/nipcb_pkg.sv | 38 +++
 rtl/nipcb_recording_reader.sv | 169 ++++++++++++++++
 tb/tb_nipcb_recording_reader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nipcb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nipcb_pkg
//  Description : Shared types, constants and helpers for the NIPCB recording
//                path: default channel geometry, the recording-reader state
//                encoding, and the lowest-set-bit search used to walk a channel
//                mask from channel 0 upwards.
//  Revision    : 1.0 - initial release
// ============================================================================
package nipcb_pkg;

    localparam int NI_N_CH     = 4;   // channels packed per recording word
    localparam int NI_SAMPLE_W = 8;   // bits per channel sample
    localparam int NI_SEQ_W    = 16;  // word sequence counter width
    localparam int NI_MAX_CH   = 32;  // widest mask ni_lowest_set accepts

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_LATCH = 2'd2,
        ST_EMIT  = 2'd3
    } ni_rd_state_e;

    // Index of the lowest set bit of mask; 0 when mask is all zero.
    // Callers zero-extend narrower masks to NI_MAX_CH bits.
    function automatic int ni_lowest_set(input logic [NI_MAX_CH-1:0] mask);
        int idx;
        idx = 0;
        for (int i = NI_MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage : nipcb_pkg
`default_nettype wire

// File: rtl/nipcb_recording_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nipcb_recording_reader
//  Description : Drains the recording FIFO filled by nipcb_core and unpacks
//                each word (N_CH samples of SAMPLE_W bits, ch0 in the LSBs)
//                into a valid/ready sample stream tagged with channel index,
//                word sequence number and an end-of-word marker.
//  Ports       :
//    clk, rst        - clock, synchronous active-high reset
//    clear           - synchronous flush of word in flight and counters
//    channel_mask    - channels to emit, sampled when a word is captured
//    fifo_dout       - FIFO read data, valid one cycle after fifo_rd
//    fifo_empty      - FIFO empty flag
//    fifo_rd         - FIFO pop strobe, one cycle per word
//    m_tdata/m_tchan/m_tseq/m_tlast/m_tvalid/m_tready - sample stream
//    busy            - FSM not in IDLE
//    words_dropped   - saturating count of words popped with an empty mask
//  Revision    : 1.0 - initial release
// ============================================================================
module nipcb_recording_reader
    import nipcb_pkg::*;
#(
    parameter int N_CH     = NI_N_CH,
    parameter int SAMPLE_W = NI_SAMPLE_W,
    parameter int SEQ_W    = NI_SEQ_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [N_CH-1:0]            channel_mask,
    input  logic [N_CH*SAMPLE_W-1:0]   fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd,
    output logic [SAMPLE_W-1:0]        m_tdata,
    output logic [$clog2(N_CH)-1:0]    m_tchan,
    output logic [SEQ_W-1:0]           m_tseq,
    output logic                       m_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       busy,
    output logic [31:0]                words_dropped
);

    localparam int C_CH_W   = $clog2(N_CH);
    localparam int C_WORD_W = N_CH * SAMPLE_W;

    ni_rd_state_e            r_state;
    logic                    r_rd;
    logic [C_WORD_W-1:0]     r_word;
    logic [N_CH-1:0]         r_mask;     // channels of the current word not yet accepted
    logic [SEQ_W-1:0]        r_seq;

    logic [C_CH_W-1:0]       w_first_idx;
    logic [N_CH-1:0]         w_first_rest;
    logic [N_CH-1:0]         w_rem;
    logic [C_CH_W-1:0]       w_next_idx;
    logic [N_CH-1:0]         w_next_rest;
    logic                    w_hs;

    // Channel walk. At capture the first channel comes straight from the live
    // mask; during EMIT the next channel comes from the mask register with the
    // channel just accepted removed. A channel is "last" when nothing above it
    // remains, which is the same as nothing at all remaining once it is removed,
    // because channels are always taken lowest first.
    always_comb begin
        w_first_idx  = C_CH_W'(ni_lowest_set(NI_MAX_CH'(channel_mask)));
        w_first_rest = channel_mask & ~(N_CH'(1) << w_first_idx);
        w_rem        = r_mask & ~(N_CH'(1) << m_tchan);
        w_next_idx   = C_CH_W'(ni_lowest_set(NI_MAX_CH'(w_rem)));
        w_next_rest  = w_rem & ~(N_CH'(1) << w_next_idx);
    end

    assign w_hs = m_tvalid & m_tready;

    // The pop strobe is registered, so it is masked here to guarantee that
    // a reset or flush arriving in the pop cycle cancels the pop outright
    // rather than leaving a word popped but never captured.
    assign fifo_rd = r_rd & ~clear & ~rst;

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rd          <= 1'b0;
            r_word        <= '0;
            r_mask        <= '0;
            r_seq         <= '0;
            m_tdata       <= '0;
            m_tchan       <= '0;
            m_tseq        <= '0;
            m_tlast       <= 1'b0;
            m_tvalid      <= 1'b0;
            words_dropped <= '0;
        end else if (clear) begin
            // Abandon whatever is in flight; the next word starts at seq 0.
            r_state       <= ST_IDLE;
            r_rd          <= 1'b0;
            r_mask        <= '0;
            r_seq         <= '0;
            m_tseq        <= '0;
            m_tlast       <= 1'b0;
            m_tvalid      <= 1'b0;
            words_dropped <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_rd    <= 1'b1;
                        r_state <= ST_POP;
                    end
                end

                ST_POP: begin
                    // Pop went out last cycle; data appears next cycle.
                    r_rd    <= 1'b0;
                    r_state <= ST_LATCH;
                end

                ST_LATCH: begin
                    r_word <= fifo_dout;
                    r_mask <= channel_mask;
                    if (channel_mask == '0) begin
                        if (words_dropped != 32'hFFFF_FFFF) begin
                            words_dropped <= words_dropped + 32'd1;
                        end
                        r_seq   <= r_seq + SEQ_W'(1);
                        r_state <= ST_IDLE;
                    end else begin
                        m_tdata  <= fifo_dout[w_first_idx*SAMPLE_W +: SAMPLE_W];
                        m_tchan  <= w_first_idx;
                        m_tseq   <= r_seq;
                        m_tlast  <= (w_first_rest == '0);
                        m_tvalid <= 1'b1;
                        r_state  <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (w_hs) begin
                        r_mask <= w_rem;
                        if (w_rem != '0) begin
                            // Next channel back-to-back; valid stays high.
                            m_tdata <= r_word[w_next_idx*SAMPLE_W +: SAMPLE_W];
                            m_tchan <= w_next_idx;
                            m_tlast <= (w_next_rest == '0);
                        end else begin
                            r_seq    <= r_seq + SEQ_W'(1);
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            if (!fifo_empty) begin
                                r_rd    <= 1'b1;
                                r_state <= ST_POP;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : nipcb_recording_reader
`default_nettype wire

// File: tb/tb_nipcb_recording_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nipcb_recording_reader
//  Description : Self-checking bench for nipcb_recording_reader. A behavioural
//                FIFO feeds the reader; a scoreboard queue holds the expected
//                beats for every word pushed. A second reader with a 2-bit
//                sequence counter runs on identical inputs so that counter
//                wrap-around is observed within a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nipcb_recording_reader;

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  chan;
        logic [15:0] seq;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  channel_mask = 4'hF;
    logic [31:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd;
    logic [7:0]  m_tdata;
    logic [1:0]  m_tchan;
    logic [15:0] m_tseq;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        busy;
    logic [31:0] words_dropped;

    // Narrow-sequence instance
    logic        n_fifo_rd;
    logic [7:0]  n_tdata;
    logic [1:0]  n_tchan;
    logic [1:0]  n_tseq;
    logic        n_tlast;
    logic        n_tvalid;
    logic        n_busy;
    logic [31:0] n_dropped;

    // FIFO model
    logic        push_valid = 1'b0;
    logic [31:0] push_data = '0;
    logic [31:0] fifo_q[$];
    int          rd_count = 0;
    logic        rd_bad = 1'b0;

    // Scoreboard / bookkeeping
    beat_t       exp_q[$];
    logic [15:0] exp_seq = '0;
    logic [31:0] exp_drop = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    logic        prev_notlast = 1'b0;
    logic        b2b_mode = 1'b0;

    always #5 clk = ~clk;

    nipcb_recording_reader #(.N_CH(4), .SAMPLE_W(8), .SEQ_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .channel_mask(channel_mask),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .m_tdata(m_tdata), .m_tchan(m_tchan), .m_tseq(m_tseq), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy),
        .words_dropped(words_dropped)
    );

    nipcb_recording_reader #(.N_CH(4), .SAMPLE_W(8), .SEQ_W(2)) dut_n (
        .clk(clk), .rst(rst), .clear(clear), .channel_mask(channel_mask),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd(n_fifo_rd),
        .m_tdata(n_tdata), .m_tchan(n_tchan), .m_tseq(n_tseq), .m_tlast(n_tlast),
        .m_tvalid(n_tvalid), .m_tready(m_tready), .busy(n_busy),
        .words_dropped(n_dropped)
    );

    // Registered-output FIFO: pop data appears the cycle after fifo_rd.
    always @(posedge clk) begin
        if (fifo_rd) begin
            if (fifo_q.size() == 0) rd_bad <= 1'b1;
            else fifo_dout <= fifo_q.pop_front();
            rd_count <= rd_count + 1;
        end
        if (push_valid) fifo_q.push_back(push_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge with inputs final for the coming rising edge:
    // scores the handshake (if any) that edge will perform, then advances.
    task automatic tick();
        beat_t e;
        if (m_tvalid && m_tready) begin
            chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tdata", 32'(m_tdata), 32'(e.data));
                chk("tchan", 32'(m_tchan), 32'(e.chan));
                chk("tseq",  32'(m_tseq),  32'(e.seq));
                chk("tlast", 32'(m_tlast), 32'(e.last));
                chk("narrow_tvalid", 32'(n_tvalid), 32'd1);
                chk("narrow_tseq", 32'(n_tseq), 32'(e.seq[1:0]));
            end
            if (b2b_mode && prev_notlast) chk("b2b_gap", 32'(cyc - last_hs_cyc), 32'd1);
            prev_notlast = !m_tlast;
            last_hs_cyc  = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic expect_word(input logic [31:0] data, input logic [3:0] mask);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                b.data = data[i*8 +: 8];
                b.chan = 2'(i);
                b.seq  = exp_seq;
                b.last = ((mask >> (i + 1)) == 4'd0);
                exp_q.push_back(b);
            end
        end
        if (mask == 4'd0) exp_drop = exp_drop + 32'd1;
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic send_word(input logic [31:0] data);
        expect_word(data, channel_mask);
        push_valid = 1'b1;
        push_data  = data;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !(exp_q.size() == 0 && !busy && fifo_empty && !push_valid)) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic wait_chan(input logic [1:0] ch);
        int n;
        n = 0;
        while (!(m_tvalid && m_tchan == ch) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_chan", 32'(m_tvalid && m_tchan == ch), 32'd1);
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_seq      = '0;
        exp_drop     = '0;
        prev_notlast = 1'b0;
    endtask

    initial begin
        int rc;

        // ---- Reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tchan", 32'(m_tchan), 32'd0);
        chk("rst_tseq", 32'(m_tseq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dropped", words_dropped, 32'd0);
        rst = 1'b0;
        tick();

        // ---- 1: full mask, four back-to-back samples, one pop ----
        b2b_mode = 1'b1;
        rc = rd_count;
        channel_mask = 4'hF;
        send_word(32'h4433_2211);
        drain(40);
        chk("t1_pops", 32'(rd_count - rc), 32'd1);

        // ---- 2: sparse mask 1010 ----
        channel_mask = 4'b1010;
        send_word(32'h4433_2211);
        drain(40);

        // ---- 3: backpressure on the ch2 beat, second word queued ----
        b2b_mode = 1'b0;
        channel_mask = 4'hF;
        send_word(32'h4433_2211);
        send_word(32'h8877_6655);
        wait_chan(2'd2);
        m_tready = 1'b0;
        rc = rd_count;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_tdata", 32'(m_tdata), 32'h33);
            chk("t3_hold_tchan", 32'(m_tchan), 32'd2);
            chk("t3_hold_tvalid", 32'(m_tvalid), 32'd1);
            chk("t3_no_fifo_rd", 32'(fifo_rd), 32'd0);
            tick();
        end
        chk("t3_no_pop_stalled", 32'(rd_count - rc), 32'd0);
        m_tready = 1'b1;
        drain(60);

        // ---- 4: empty mask drops words, sequence still advances ----
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush_model();
        chk("clr_dropped", words_dropped, 32'd0);
        rc = rd_count;
        channel_mask = 4'h0;
        send_word(32'hAAAA_AAAA);
        send_word(32'hBBBB_BBBB);
        send_word(32'hCCCC_CCCC);
        drain(60);
        chk("t4_pops", 32'(rd_count - rc), 32'd3);
        chk("t4_dropped", words_dropped, exp_drop);
        channel_mask = 4'hF;
        send_word(32'hD4D3_D2D1);   // expected tseq 3
        drain(40);

        // ---- 5: clear during the ch1 beat, then reset during the ch1 beat ----
        send_word(32'h0403_0201);
        wait_chan(2'd1);
        m_tready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_tready = 1'b1;
        flush_model();
        chk("t5_tvalid_after_clear", 32'(m_tvalid), 32'd0);
        chk("t5_busy_after_clear", 32'(busy), 32'd0);
        chk("t5_dropped_after_clear", words_dropped, 32'd0);
        tick();
        chk("t5_no_stray_beat", 32'(m_tvalid), 32'd0);
        send_word(32'h1413_1211);   // expected tseq 0
        drain(40);

        send_word(32'h2423_2221);
        wait_chan(2'd1);
        m_tready = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5r_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("t5r_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5r_tlast", 32'(m_tlast), 32'd0);
        chk("t5r_tdata", 32'(m_tdata), 32'd0);
        chk("t5r_tchan", 32'(m_tchan), 32'd0);
        chk("t5r_tseq", 32'(m_tseq), 32'd0);
        chk("t5r_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        m_tready = 1'b1;
        flush_model();
        tick();
        send_word(32'h3433_3231);   // expected tseq 0 after reset
        drain(40);

        // ---- 6: idle on an empty FIFO, then sequence wrap on the narrow instance ----
        rc = rd_count;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_no_pop_when_empty", 32'(rd_count - rc), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        channel_mask = 4'b0001;
        for (int i = 0; i < 5; i++) send_word(32'h0000_0050 + 32'(i));
        drain(80);
        chk("t6_seq_after_wrap", 32'(exp_seq), 32'd6);
        chk("fifo_rd_while_empty", 32'(rd_bad), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nipcb_recording_reader
`default_nettype wire
